dot11_rx_ctrl: RTL

Bring-up and configuration sequencer for the dot11 receive pipeline. After reset or a `restart` request it:

- holds the receiver in reset;
- writes a parameterised table of setting-bus registers (for example `SR_SKIP_SAMPLE`);
- then enables the receiver and opens the sample path.

In run state it arbitrates host setting writes onto the single `set_stb/set_addr/set_data` bus. It sits between the sample source/host and the `dot11` instance, whose `reset`, `enable`, setting and sample inputs it drives.

---
 rtl/dot11_rx_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dot11_rx_ctrl.sv
// Bring-up and configuration sequencer for the dot11 receive pipeline.
// Sequences receiver reset, setting-table writes and host setting arbitration; gates the sample path.
module dot11_rx_ctrl #(
  parameter int           NUM_INIT   = 1,
  parameter logic [31:0]  INIT_ADDRS = 32'h0,
  parameter logic [127:0] INIT_DATAS = 128'h0,
  parameter int           RST_CYCLES = 4,
  parameter int           SET_GAP    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        restart,
  input  logic        host_req,
  input  logic [7:0]  host_addr,
  input  logic [31:0] host_data,
  output logic        host_ack,
  input  logic [31:0] sample_in,
  input  logic        sample_in_strobe,
  output logic [31:0] sample_out,
  output logic        sample_out_strobe,
  output logic        rx_reset,
  output logic        rx_enable,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic        ready,
  output logic [15:0] drop_count
);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES);
  localparam logic [15:0] GAP_LAST = 16'(SET_GAP);
  localparam logic [2:0]  NUM_LAST = 3'(NUM_INIT);

  logic [1:0]  state;
  logic [15:0] rst_cnt;
  logic [15:0] gap_cnt;
  logic [2:0]  init_idx;
  logic        gap_ok;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] init_addr(input logic [1:0] k);
    return INIT_ADDRS[{k, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] init_data(input logic [1:0] k);
    return INIT_DATAS[{k, 5'b00000} +: 32];
  endfunction

  // gap_cnt saturates at SET_GAP, so it reads as "enough idle cycles since the last strobe"
  assign gap_ok = (gap_cnt >= GAP_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= S_RESET;
      rst_cnt           <= 16'd0;
      gap_cnt           <= 16'd0;
      init_idx          <= 3'd0;
      rx_reset          <= 1'b1;
      rx_enable         <= 1'b0;
      ready             <= 1'b0;
      set_stb           <= 1'b0;
      host_ack          <= 1'b0;
      set_addr          <= 8'd0;
      set_data          <= 32'd0;
      sample_out        <= 32'd0;
      sample_out_strobe <= 1'b0;
      drop_count        <= 16'd0;
    end else begin
      set_stb  <= 1'b0;
      host_ack <= 1'b0;
      if (!gap_ok) gap_cnt <= gap_cnt + 16'd1;

      // restart edge is cycle 0, so the count resumes at 1 to match the reset-release timing
      if (restart) begin
        state     <= S_RESET;
        rst_cnt   <= 16'd1;
        gap_cnt   <= 16'd0;
        init_idx  <= 3'd0;
        rx_reset  <= 1'b1;
        rx_enable <= 1'b0;
        ready     <= 1'b0;
      end else begin
        case (state)
          S_RESET: begin
            if (rst_cnt >= RST_LAST) begin
              rx_reset <= 1'b0;
              if (NUM_LAST == 3'd0) begin
                state     <= S_RUN;
                rx_enable <= 1'b1;
                ready     <= 1'b1;
                gap_cnt   <= GAP_LAST;
              end else begin
                state    <= S_INIT;
                set_stb  <= 1'b1;
                set_addr <= init_addr(2'd0);
                set_data <= init_data(2'd0);
                init_idx <= 3'd1;
                gap_cnt  <= 16'd0;
              end
            end else begin
              rst_cnt <= rst_cnt + 16'd1;
            end
          end
          S_INIT: begin
            if (gap_ok) begin
              if (init_idx >= NUM_LAST) begin
                state     <= S_RUN;
                rx_enable <= 1'b1;
                ready     <= 1'b1;
              end else begin
                set_stb  <= 1'b1;
                set_addr <= init_addr(init_idx[1:0]);
                set_data <= init_data(init_idx[1:0]);
                init_idx <= init_idx + 3'd1;
                gap_cnt  <= 16'd0;
              end
            end
          end
          S_RUN: begin
            if (host_req && gap_ok) begin
              set_stb  <= 1'b1;
              host_ack <= 1'b1;
              set_addr <= host_addr;
              set_data <= host_data;
              gap_cnt  <= 16'd0;
            end
          end
          default: begin
            state    <= S_RESET;
            rst_cnt  <= 16'd0;
            rx_reset <= 1'b1;
          end
        endcase
      end

      // sample path runs independently of the sequencer
      sample_out        <= sample_in;
      sample_out_strobe <= sample_in_strobe & rx_enable;
      if (sample_in_strobe && !rx_enable) drop_count <= sat_inc16(drop_count);
    end
  end

endmodule
